// File: rtl/apu_frame_sequencer.sv
// apu_frame_sequencer: APU frame counter that emits quarter/half-frame strobes, step index and frame IRQ
module apu_frame_sequencer #(
  parameter int STEP1 = 7457,
  parameter int STEP2 = 14913,
  parameter int STEP3 = 22371,
  parameter int STEP4 = 29829,
  parameter int STEP5 = 37281,
  parameter int CNT_WIDTH = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cfg_wr,
  input  logic       cfg_mode,
  input  logic       cfg_irq_inhibit,
  input  logic       irq_ack,
  output logic       quarter_frame,
  output logic       half_frame,
  output logic       frame_irq,
  output logic [2:0] step
);
  logic [CNT_WIDTH-1:0] count, count_n;
  logic mode, inhibit, wrap, q_n, h_n, irq_n;
  logic [4:0] hit;
  logic [2:0] step_n;
  always_comb begin
    hit[0] = count == CNT_WIDTH'(STEP1);
    hit[1] = count == CNT_WIDTH'(STEP2);
    hit[2] = count == CNT_WIDTH'(STEP3);
    hit[3] = count == CNT_WIDTH'(STEP4);
    hit[4] = mode && count == CNT_WIDTH'(STEP5);
    wrap = mode ? hit[4] : hit[3];
    count_n = (cfg_wr || wrap) ? '0 : count + CNT_WIDTH'(1);
    // a config write restarts the sequence and overrides any step match on the same edge
    q_n = cfg_wr ? cfg_mode : hit[0] | hit[1] | hit[2] | wrap;
    h_n = cfg_wr ? cfg_mode : hit[1] | wrap;
    step_n = cfg_wr ? 3'd0 : hit[4] ? 3'd5 : hit[3] ? 3'd4 : hit[2] ? 3'd3 :
             hit[1] ? 3'd2 : hit[0] ? 3'd1 : step;
    irq_n = cfg_wr ? frame_irq & !irq_ack & !cfg_irq_inhibit
                   : (hit[3] & !mode & !inhibit) | (frame_irq & !irq_ack);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
      mode <= 1'b0;
      inhibit <= 1'b0;
      step <= 3'd0;
      quarter_frame <= 1'b0;
      half_frame <= 1'b0;
      frame_irq <= 1'b0;
    end else begin
      count <= count_n;
      if (cfg_wr) begin
        mode <= cfg_mode;
        inhibit <= cfg_irq_inhibit;
      end
      step <= step_n;
      quarter_frame <= q_n;
      half_frame <= h_n;
      frame_irq <= irq_n;
    end
  end
endmodule

// File: tb/tb_apu_frame_sequencer.sv
// tb_apu_frame_sequencer: checks a default-size and a shrunken sequencer against a position-based model
module tb_apu_frame_sequencer;
  localparam int S1 = 10, S2 = 21, S3 = 32, S4 = 43, S5 = 54;
  logic clk = 0, reset = 1, cfg_wr = 0, cfg_mode = 0, cfg_irq_inhibit = 0, irq_ack = 0;
  logic qf, hf, irqf, qs, hs, irqs;
  logic [2:0] stf, sts;
  logic [5:0] o0, o1;
  int checks = 0, failures = 0, cyc = 0;
  bit run = 0;
  int m_e [2];
  bit m_mode [2], m_inh [2], m_ws [2], m_irq [2];

  assign o0 = {qf, hf, irqf, stf};
  assign o1 = {qs, hs, irqs, sts};

  apu_frame_sequencer dut_full (
    .clk(clk), .reset(reset), .cfg_wr(cfg_wr), .cfg_mode(cfg_mode),
    .cfg_irq_inhibit(cfg_irq_inhibit), .irq_ack(irq_ack),
    .quarter_frame(qf), .half_frame(hf), .frame_irq(irqf), .step(stf)
  );
  apu_frame_sequencer #(.STEP1(S1), .STEP2(S2), .STEP3(S3), .STEP4(S4), .STEP5(S5), .CNT_WIDTH(6)) dut_small (
    .clk(clk), .reset(reset), .cfg_wr(cfg_wr), .cfg_mode(cfg_mode),
    .cfg_irq_inhibit(cfg_irq_inhibit), .irq_ack(irq_ack),
    .quarter_frame(qs), .half_frame(hs), .frame_irq(irqs), .step(sts)
  );

  always #5 clk = ~clk;

  function automatic int st(input int k, input int i);
    case (i)
      1: return k ? S1 : 7457;
      2: return k ? S2 : 14913;
      3: return k ? S3 : 22371;
      4: return k ? S4 : 29829;
      default: return k ? S5 : 37281;
    endcase
  endfunction

  function automatic int period(input int k);
    return st(k, m_mode[k] ? 5 : 4) + 1;
  endfunction

  // Expected outputs from the position inside the current frame period.
  function automatic logic [5:0] expect_out(input int k);
    int ws, per, p;
    logic q, h;
    logic [2:0] s;
    ws = m_mode[k] ? 5 : 4;
    per = period(k);
    if (m_e[k] == 0) return {m_ws[k], m_ws[k], m_irq[k], 3'd0};
    p = (m_e[k] - 1) % per;
    q = 0;
    h = 0;
    s = 0;
    for (int i = 1; i <= ws; i++) begin
      if (st(k, i) == p) begin
        q = (i != 4) || (ws == 4);
        h = (i == 2) || (i == ws);
      end
      if (st(k, i) <= p) s = 3'(i);
    end
    if (s == 0 && m_e[k] - 1 >= per) s = 3'(ws);
    return {q, h, m_irq[k], s};
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      cyc = 0;
      for (int k = 0; k < 2; k++) begin
        m_e[k] = 0; m_mode[k] = 0; m_inh[k] = 0; m_ws[k] = 0; m_irq[k] = 0;
      end
    end else begin
      cyc++;
      for (int k = 0; k < 2; k++) begin
        if (cfg_wr) begin
          m_mode[k] = cfg_mode;
          m_inh[k] = cfg_irq_inhibit;
          m_e[k] = 0;
          m_ws[k] = cfg_mode;
          m_irq[k] = cfg_irq_inhibit ? 0 : m_irq[k] && !irq_ack;
        end else begin
          m_e[k]++;
          m_irq[k] = (!m_mode[k] && !m_inh[k] && ((m_e[k] - 1) % period(k)) == st(k, 4))
                     || (m_irq[k] && !irq_ack);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (run) begin
      for (int k = 0; k < 2; k++) begin
        logic [5:0] act, exp;
        act = k ? o1 : o0;
        exp = expect_out(k);
        checks++;
        if (act !== exp) begin
          failures++;
          $display("FAIL model dut%0d cyc=%0d got q,h,irq,step=%b expected %b", k, cyc, act, exp);
        end
      end
    end
  end

  task automatic lit(input string name, input logic [5:0] act, input logic [5:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got q,h,irq,step=%b expected %b", name, cyc, act, exp);
    end
  endtask

  task automatic at(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  initial begin
    int w, c0;
    repeat (2) @(negedge clk);
    run = 1;
    lit("reset_full", o0, 6'b000000);
    lit("reset_small", o1, 6'b000000);
    reset = 0;
    at(7457);  lit("full_pre_q1", o0, 6'b000000);
    at(7458);  lit("full_q1", o0, 6'b100001);
    at(14914); lit("full_qh2", o0, 6'b110010);
    at(22372); lit("full_q3", o0, 6'b100011);
    at(29829); irq_ack = 1;
    at(29830); irq_ack = 0;
    lit("full_irq_set_wins", o0, 6'b111100);
    irq_ack = 1;
    at(29831); irq_ack = 0;
    lit("full_irq_ack", o0, 6'b000100);
    at(37288); lit("full_wrap_q1", o0, 6'b100001);
    at(37289); cfg_wr = 1; cfg_mode = 1; cfg_irq_inhibit = 1;
    w = 37290;
    at(w); cfg_wr = 0;
    lit("small_wr5_clock", o1, 6'b110000);
    lit("full_wr5_clock", o0, 6'b110000);
    at(w + 11); lit("small5_q1", o1, 6'b100001);
    at(w + 44); lit("small5_step4_silent", o1, 6'b000100);
    at(w + 55); lit("small5_qh5", o1, 6'b110101);
    at(w + 56); lit("small5_step_hold", o1, 6'b000101);
    at(w + 7458); lit("full5_q1", o0, 6'b100001);
    at(w + 20000);
    #2 reset = 1;
    #1 lit("async_reset_full", o0, 6'b000000);
    lit("async_reset_small", o1, 6'b000000);
    repeat (2) @(negedge clk);
    reset = 0;
    at(7457); lit("full_rst_pre_q1", o0, 6'b000000);
    at(7458); lit("full_rst_q1", o0, 6'b100001);
    c0 = cyc;
    at(c0 + ((S2 - c0 % (S4 + 1)) + (S4 + 1)) % (S4 + 1));
    cfg_wr = 1; cfg_mode = 0; cfg_irq_inhibit = 1;
    w = cyc + 1;
    at(w); cfg_wr = 0;
    lit("small_wr_on_step2", o1, 6'b000000);
    at(w + 10); lit("small_restart_pre_q1", o1, 6'b000000);
    at(w + 11); lit("small_restart_q1", o1, 6'b100001);
    at(w + 44); lit("small_inh_p1", o1, 6'b110100);
    at(w + 88); lit("small_inh_p2", o1, 6'b110100);
    at(w + 99); cfg_wr = 1; cfg_mode = 0; cfg_irq_inhibit = 0;
    w = w + 100;
    at(w); cfg_wr = 0;
    lit("small_uninhibit_no_irq", o1, 6'b000000);
    at(w + 43); lit("small_pre_irq", o1, 6'b000011);
    at(w + 44); lit("small_first_irq", o1, 6'b111100);
    at(w + 50); cfg_wr = 1; cfg_irq_inhibit = 1; irq_ack = 1;
    at(w + 51); cfg_wr = 0; irq_ack = 0;
    lit("small_wr_inh_ack", o1, 6'b000000);
    at(w + 60);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
